// File: rtl/perceptron_train_ctrl.sv
// Weight-RAM port scheduler for the perceptron predictor: fetch lookups own the port, training updates
// run as read-modify-write in idle cycles. Define PERCEPTRON_TRAIN_STATS_EN to add the stat_train/stat_filt counters.
module perceptron_train_ctrl #(
    parameter int HIST_LEN   = 8,
    parameter int WBITS      = 8,
    parameter int IDX_BITS   = 6,
    parameter int FIFO_DEPTH = 4,
    parameter int THETA      = 29,
    localparam int RW        = (HIST_LEN + 1) * WBITS,
    localparam int SUM_W     = WBITS + $clog2(HIST_LEN + 1) + 1
) (
    input  logic                    CLK,
    input  logic                    RES,
    input  logic                    lk_req,
    input  logic [IDX_BITS-1:0]     lk_idx,
    input  logic                    tr_valid,
    output logic                    tr_ready,
    input  logic [IDX_BITS-1:0]     tr_idx,
    input  logic [HIST_LEN-1:0]     tr_hist,
    input  logic                    tr_taken,
    input  logic                    tr_pred,
    input  logic signed [SUM_W-1:0] tr_sum,
    output logic                    ram_en,
    output logic                    ram_we,
    output logic [IDX_BITS-1:0]     ram_addr,
    output logic [RW-1:0]           ram_wdata,
    input  logic [RW-1:0]           ram_rdata,
    output logic                    busy
`ifdef PERCEPTRON_TRAIN_STATS_EN
    ,
    output logic [31:0]             stat_train,
    output logic [31:0]             stat_filt
`endif
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int ENT_W = IDX_BITS + HIST_LEN + 1;
    localparam logic [SUM_W:0] THETA_M = (SUM_W + 1)'(THETA);
    localparam logic signed [WBITS-1:0] WMAX = {1'b0, {(WBITS-1){1'b1}}};
    localparam logic signed [WBITS-1:0] WMIN = {1'b1, {(WBITS-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, RD, UPD, WR} state_t;

    state_t                state_q, state_d;
    logic [PTR_W:0]        wr_ptr, rd_ptr;
    logic                  rdy_q;
    logic [ENT_W-1:0]      fifo_mem [FIFO_DEPTH];
    logic [IDX_BITS-1:0]   wk_idx;
    logic [HIST_LEN-1:0]   wk_hist;
    logic                  wk_taken;
    logic [RW-1:0]         row_q;
    logic                  empty, full, accept, need_train, push, pop;

    // One extra bit so the most-negative sum has a representable magnitude
    function automatic logic [SUM_W:0] mag(input logic signed [SUM_W-1:0] s);
        logic [SUM_W:0] e;
        e = {s[SUM_W-1], s};
        return s[SUM_W-1] ? (~e + 1'b1) : e;
    endfunction

    function automatic logic signed [WBITS-1:0] sat_step(input logic signed [WBITS-1:0] w, input logic up);
        if (up)
            return (w == WMAX) ? w : w + WBITS'(1);
        return (w == WMIN) ? w : w - WBITS'(1);
    endfunction

    function automatic logic [RW-1:0] upd_row(input logic [RW-1:0] row, input logic [HIST_LEN-1:0] h,
                                              input logic tk);
        logic [RW-1:0] r;
        r = row;
        r[0 +: WBITS] = sat_step(row[0 +: WBITS], tk);
        for (int i = 1; i <= HIST_LEN; i++)
            r[i*WBITS +: WBITS] = sat_step(row[i*WBITS +: WBITS], h[i-1] ? tk : !tk);
        return r;
    endfunction

    assign empty      = (wr_ptr == rd_ptr);
    assign full       = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) && (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign tr_ready   = rdy_q && !full;
    assign accept     = tr_valid && tr_ready;
    assign need_train = (tr_taken != tr_pred) || (mag(tr_sum) <= THETA_M);
    assign push       = accept && need_train;
    assign pop        = (state_q == IDLE) && !empty;
    assign busy       = (state_q != IDLE) || !empty;

    // Port outputs are forced quiet while reset is held, even with a lookup pending
    always_comb begin
        state_d   = state_q;
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        if (RES) begin
            if (lk_req) begin
                ram_en   = 1'b1;
                ram_addr = lk_idx;
            end
            case (state_q)
                IDLE: if (!empty) state_d = RD;
                RD: if (!lk_req) begin
                    ram_en   = 1'b1;
                    ram_addr = wk_idx;
                    state_d  = UPD;
                end
                UPD: state_d = WR;
                WR: if (!lk_req) begin
                    ram_en    = 1'b1;
                    ram_we    = 1'b1;
                    ram_addr  = wk_idx;
                    ram_wdata = row_q;
                    state_d   = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RES) begin
        if (!RES) begin
            state_q <= IDLE;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rdy_q   <= 1'b1;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (push) fifo_mem[wr_ptr[PTR_W-1:0]] <= {tr_idx, tr_hist, tr_taken};
        if (pop)  {wk_idx, wk_hist, wk_taken} <= fifo_mem[rd_ptr[PTR_W-1:0]];
        if (state_q == UPD) row_q <= upd_row(ram_rdata, wk_hist, wk_taken);
    end

`ifdef PERCEPTRON_TRAIN_STATS_EN
    always_ff @(posedge CLK or negedge RES) begin
        if (!RES) begin
            stat_train <= '0;
            stat_filt  <= '0;
        end else begin
            if (ram_we)                 stat_train <= stat_train + 32'd1;
            if (accept && !need_train)  stat_filt  <= stat_filt + 32'd1;
        end
    end
`endif

endmodule

// File: doc/perceptron_train_ctrl.md
Name: perceptron_train_ctrl

Overview:
Scheduler for the perceptron branch predictor's single-port weight RAM, shared between fetch-stage lookups and execute-stage training updates. Fetch lookups always win the port. Training requests are filtered by the perceptron rule, queued in a small FIFO, and applied as read-modify-write sequences in idle port cycles. Sits between the core's fetch/execute feedback paths and the weight RAM.

Parameters:
HIST_LEN, 8, global history bits; weights per row = HIST_LEN+1 (w0 is the bias).
WBITS, 8, signed weight width; saturating range -2^(WBITS-1)..2^(WBITS-1)-1.
IDX_BITS, 6, weight-row index width.
FIFO_DEPTH, 4, training queue entries (power of 2, >=2).
THETA, 29, training threshold (floor(1.93*HIST_LEN+14)).
Localparams: RW = (HIST_LEN+1)*WBITS; SUM_W = WBITS+$clog2(HIST_LEN+1)+1.

Ports:
CLK  in  1  clock, rising edge
RES  in  1  reset, asynchronous, active-low
lk_req  in  1  fetch lookup request this cycle
lk_idx  in  IDX_BITS  lookup row index
tr_valid  in  1  training request valid
tr_ready  out  1  training request accepted when tr_valid&tr_ready
tr_idx  in  IDX_BITS  row index used at prediction
tr_hist  in  HIST_LEN  history used at prediction (1 = taken)
tr_taken  in  1  resolved outcome
tr_pred  in  1  predicted outcome
tr_sum  in  SUM_W  signed perceptron output at prediction
ram_en  out  1  RAM access enable
ram_we  out  1  RAM write enable
ram_addr  out  IDX_BITS  RAM row address
ram_wdata  out  RW  write row; weight i at bits [i*WBITS +: WBITS], i=0 is the bias
ram_rdata  in  RW  read row, valid the cycle after a read
busy  out  1  FSM not IDLE or FIFO non-empty

Behaviour:
- While RES is low: FSM=IDLE, FIFO empty, tr_ready=0, ram_en=0, ram_we=0, ram_addr=0, ram_wdata=0, busy=0. RAM contents are untouched. Reset asserted mid-sequence abandons the in-flight update; a partial write never occurs.
- Filter at acceptance: an accepted request is enqueued only if tr_taken!=tr_pred or |tr_sum|<=THETA. Otherwise it is discarded (handshake still completes). |tr_sum| uses a SUM_W+1-bit magnitude; the most-negative value is handled.
- tr_ready = !full (registered-state based). There is no enqueue when full, even if a pop occurs in the same cycle.
- Port priority: when lk_req=1, ram_en=1, ram_we=0, ram_addr=lk_idx, and the training FSM does not touch the port that cycle.
- FSM:
  - IDLE: if FIFO non-empty, pop the head into the working register and go to RD.
  - RD: if !lk_req, issue the read (ram_en=1, addr=idx) and go to UPD; otherwise stay in RD.
  - UPD: capture ram_rdata. Compute t=+1 if taken else -1. w0+=t. wi+=(hist[i-1]?t:-t) for i=1..HIST_LEN. Each sum saturates to the WBITS signed range. Register the result and go to WR. No port use in UPD.
  - WR: if !lk_req, assert ram_en=1, ram_we=1, addr=idx, wdata=updated row, then go to IDLE; otherwise stay in WR with wdata held.
- Uncontended latency: pop (IDLE) -> read at +1 -> write at +3 cycles. Each update takes 4 cycles IDLE-to-IDLE.
- Stale data: a lookup of a row between its RD and WR returns pre-update weights. This is accepted behaviour. Queued requests to the same index are applied in order and serialised, so no updates are lost.
- ram_wdata=0 whenever ram_we=0.

Optional Feature:
PERCEPTRON_TRAIN_STATS_EN
- Defined: adds outputs stat_train[31:0] (updates written) and stat_filt[31:0] (requests discarded by the filter). Both are wrapping counters cleared by reset; a filtered request increments stat_filt on its accept cycle.
- Undefined: these ports and counters are absent. All other behaviour is identical.

Test Plan:
- Row 5 all-zero; train idx=5, hist=8'b1010_0101, taken=1, pred=0, sum=0; lk_req=0 -> one write at acceptance+4 cycles, addr=5, w0=+1, w1,w3,w6,w8=+1, w2,w4,w5,w7=-1 (hist[i-1] set -> +1).
- taken=pred=1, sum=+40 -> accepted, no RAM write, busy stays 0, stat_filt=1. sum=+29 -> trained. sum=-30, taken=0, pred=0 -> filtered.
- Saturation: row all +127, taken=1, hist=8'hFF -> written row all +127. Row all -128, taken=0, hist=8'hFF -> row all -128.
- Contention: enqueue one request, hold lk_req=1 for 5 cycles starting at RD -> ram_addr=lk_idx throughout and no training read. Read on the first lk_req=0 cycle, write 2 cycles later. Repeat with lk_req high during WR -> wdata held, write deferred.
- FIFO full: lk_req=1 continuously, 6 back-to-back mispredict requests -> first 5 accepted (1 in FSM plus 4 queued), tr_ready=0 on the 6th until lk_req drops. All 5 rows are later written in order.
- Drop RES in WR with lk_req=0 -> ram_we falls immediately without a clock edge, FIFO empties, tr_ready=0. After release, tr_ready=1 next cycle and no write of the abandoned row occurs.
